// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with 16x oversampling: synchronises Rx, aligns sampling to the
// start edge, samples each bit at mid-period and strobes the byte (or a framing error).
module uart_rx_8n1 #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Rx,
    output logic [7:0] Data,
    output logic       DataValid,
    output logic       FrameError,
    output logic       Busy
);

    localparam int unsigned DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SW  = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] SC_HALF   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SC_LAST   = SW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic          rx_meta, rx_s, rx_d;
    state_t        state, state_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [SW-1:0] sc, sc_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    data_n;
    logic          done, done_n;
    logic          stop_bit, stop_bit_n;
    logic          valid_n, ferr_n, busy_n;
    logic          tick_c, fall_c;

    // Two-flop synchroniser plus a third flop used only as the edge reference
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign fall_c = rx_d & ~rx_s;
    assign tick_c = (tcnt == TICK_LAST);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            tcnt       <= '0;
            sc         <= '0;
            idx        <= '0;
            shift      <= '0;
            done       <= 1'b0;
            stop_bit   <= 1'b0;
            Data       <= 8'h00;
            DataValid  <= 1'b0;
            FrameError <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            state      <= state_n;
            tcnt       <= tcnt_n;
            sc         <= sc_n;
            idx        <= idx_n;
            shift      <= shift_n;
            done       <= done_n;
            stop_bit   <= stop_bit_n;
            Data       <= data_n;
            DataValid  <= valid_n;
            FrameError <= ferr_n;
            Busy       <= busy_n;
        end
    end

    // Next state; the tick counter free-runs outside IDLE so ticks stay phase-locked to the start edge
    always_comb begin
        state_n    = state;
        tcnt_n     = tick_c ? '0 : tcnt + TW'(1);
        sc_n       = sc;
        idx_n      = idx;
        shift_n    = shift;
        done_n     = 1'b0;
        stop_bit_n = stop_bit;
        data_n     = Data;
        valid_n    = 1'b0;
        ferr_n     = 1'b0;

        case (state)
            IDLE: begin
                tcnt_n = '0;
                sc_n   = '0;
                if (fall_c) begin
                    state_n = START;
                end
            end
            START: begin
                if (tick_c) begin
                    if (sc == SC_HALF) begin
                        sc_n  = '0;
                        idx_n = '0;
                        state_n = rx_s ? IDLE : DATA;
                    end else begin
                        sc_n = sc + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick_c) begin
                    if (sc == SC_LAST) begin
                        sc_n         = '0;
                        shift_n[idx] = rx_s;
                        if (idx == 3'd7) begin
                            state_n = STOP;
                        end else begin
                            idx_n = idx + 3'd1;
                        end
                    end else begin
                        sc_n = sc + SW'(1);
                    end
                end
            end
            STOP: begin
                // Stop level is captured at mid-bit; outputs and IDLE follow one Clk later
                if (done) begin
                    state_n = IDLE;
                    if (stop_bit) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end else if (tick_c) begin
                    if (sc == SC_LAST) begin
                        sc_n       = '0;
                        done_n     = 1'b1;
                        stop_bit_n = rx_s;
                    end else begin
                        sc_n = sc + SW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed + randomized bench for uart_rx_8n1: serial frames with edge jitter are
// driven asynchronously and outputs are compared against a frame-level reference.
module tb_uart_rx_8n1;

    localparam int unsigned CLK_HZ = 1_280_000;
    localparam int unsigned BAUD   = 10_000;
    localparam int unsigned OS     = 16;
    localparam int unsigned DIV    = CLK_HZ / (BAUD * OS);
    localparam int unsigned BP     = DIV * OS;
    localparam int unsigned LAT    = 4 + 9 * BP + BP / 2;
    localparam int          CP     = 10;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Rx;
    logic [7:0] Data;
    logic       DataValid;
    logic       FrameError;
    logic       Busy;

    int          n_assert = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned n_valid  = 0;
    int unsigned n_ferr   = 0;
    int unsigned n_both   = 0;
    int unsigned n_busy   = 0;
    int unsigned last_evt = 0;
    logic [7:0]  exp_data;

    uart_rx_8n1 #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OS)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Rx        (Rx),
        .Data      (Data),
        .DataValid (DataValid),
        .FrameError(FrameError),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge
    always @(negedge Clk) begin
        if (DataValid) begin
            n_valid  <= n_valid + 1;
            last_evt <= cyc;
        end
        if (FrameError) begin
            n_ferr   <= n_ferr + 1;
            last_evt <= cyc;
        end
        if (DataValid && FrameError) n_both <= n_both + 1;
        if (Busy) n_busy <= n_busy + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One frame with +/-3 Clk jitter on each interior bit edge; checks the frame outcome
    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        int unsigned sv, sf, st;
        int j, pj;
        sv = n_valid;
        sf = n_ferr;
        st = cyc;
        pj = 0;
        Rx = 1'b0;
        for (int i = 0; i < 9; i++) begin
            j = int'($urandom_range(6)) - 3;
            #(CP * (int'(BP) + j - pj));
            pj = j;
            Rx = (i < 8) ? b[i] : stop_ok;
        end
        #(CP * (int'(BP) - pj));
        Rx = 1'b1;
        if (stop_ok) exp_data = b;
        chk("valid_count", n_valid - sv, stop_ok ? 32'd1 : 32'd0);
        chk("ferr_count", n_ferr - sf, stop_ok ? 32'd0 : 32'd1);
        chk("data", {24'd0, Data}, {24'd0, exp_data});
        chk("strobe_latency", last_evt - st, LAT);
        chk("busy_after_frame", {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        int unsigned sv, sf, sb, st;
        logic [7:0] rb;
        logic       rok;
        int unsigned gap;

        Reset_n  = 1'b0;
        Rx       = 1'b1;
        exp_data = 8'h00;
        #13;
        chk("reset_data", {24'd0, Data}, 32'd0);
        chk("reset_valid", {31'd0, DataValid}, 32'd0);
        chk("reset_ferr", {31'd0, FrameError}, 32'd0);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        #10;
        Reset_n = 1'b1;

        // Idle then a single byte
        #(CP * 2 * int'(BP));
        send_frame(8'h55, 1'b1);

        // Back-to-back frames
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        #(CP * int'(BP));

        // Short low glitch: a false start
        sv = n_valid;
        sf = n_ferr;
        sb = n_busy;
        Rx = 1'b0;
        #(CP * 3 * int'(DIV));
        Rx = 1'b1;
        #(CP * 2 * int'(BP));
        chk("glitch_busy_seen", {31'd0, (n_busy - sb) > 0}, 32'd1);
        chk("glitch_valid", n_valid - sv, 32'd0);
        chk("glitch_ferr", n_ferr - sf, 32'd0);
        chk("glitch_data", {24'd0, Data}, {24'd0, exp_data});
        chk("glitch_busy_end", {31'd0, Busy}, 32'd0);

        // Bad stop bit
        send_frame(8'hC6, 1'b0);
        #(CP * int'(BP));

        // Break: long low gives exactly one framing error
        sv = n_valid;
        sf = n_ferr;
        st = cyc;
        Rx = 1'b0;
        #(CP * 20 * int'(BP));
        Rx = 1'b1;
        #(CP * 2 * int'(BP));
        chk("break_ferr", n_ferr - sf, 32'd1);
        chk("break_valid", n_valid - sv, 32'd0);
        chk("break_latency", last_evt - st, LAT);
        chk("break_data", {24'd0, Data}, {24'd0, exp_data});
        send_frame(8'h3C, 1'b1);
        #(CP * int'(BP));

        // Reset during data bit 4 of a frame
        rb = 8'h5A;
        sv = n_valid;
        sf = n_ferr;
        Rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #(CP * int'(BP));
            Rx = rb[i];
        end
        #(CP * int'(BP));
        Rx = rb[4];
        #(CP * int'(BP / 2));
        chk("midframe_busy", {31'd0, Busy}, 32'd1);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("async_rst_data", {24'd0, Data}, 32'd0);
        chk("async_rst_valid", {31'd0, DataValid}, 32'd0);
        chk("async_rst_ferr", {31'd0, FrameError}, 32'd0);
        chk("async_rst_busy", {31'd0, Busy}, 32'd0);
        Rx = 1'b1;
        #6;
        exp_data = 8'h00;
        #(CP * 4);
        Reset_n = 1'b1;
        #(CP * 2 * int'(BP));
        chk("post_rst_valid", n_valid - sv, 32'd0);
        chk("post_rst_ferr", n_ferr - sf, 32'd0);
        chk("post_rst_data", {24'd0, Data}, 32'd0);
        send_frame(8'h81, 1'b1);

        // Randomized frames with occasional bad stop bits and random idle gaps
        for (int k = 0; k < 10; k++) begin
            rb  = 8'($urandom);
            rok = ($urandom_range(4) != 0);
            send_frame(rb, rok);
            gap = rok ? $urandom_range(BP) : BP;
            #(CP * int'(gap));
        end

        #(CP * int'(BP));
        chk("valid_ferr_exclusive", n_both, 32'd0);
        chk("final_data", {24'd0, Data}, {24'd0, exp_data});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
